// File: rtl/ddr4_ca_pkg.sv
// Shared definitions for the DDR4 CA delay-line trainer and related trainers.
package ddr4_ca_pkg;

  // Trainer sequencing states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_LOAD,
    S_WAIT,
    S_CMP,
    S_STEP,
    S_NEXT,
    S_FIN
  } state_e;

  // Default IOD tap width (TX_DELAY_VAL width) and its tap type.
  localparam int unsigned CA_TAP_W = 8;
  typedef logic [CA_TAP_W-1:0] tap_t;
  localparam tap_t TAP_MAX = '1;

endpackage

// File: rtl/ddr4_ca_dly_trainer_if.sv
// Sequencer/PHY-facing signal bundle of the CA delay-line trainer.
interface ddr4_ca_dly_trainer_if #(
  parameter int unsigned NUM_LANES = 14,
  parameter int unsigned TAP_W     = 8
);
  logic                         START;
  logic [NUM_LANES-1:0]         LANE_MASK;
  logic [NUM_LANES*TAP_W-1:0]   TARGET_TAP;
  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE;
  logic [NUM_LANES-1:0]         DELAY_LINE_LOAD;
  logic [NUM_LANES-1:0]         DELAY_LINE_MOVE;
  logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION;
  logic [NUM_LANES*TAP_W-1:0]   CUR_TAP;
  logic                         BUSY;
  logic                         DONE;
  logic [NUM_LANES-1:0]         LANE_ERR;

  // Sequencer + PHY side.
  modport master (
    output START, LANE_MASK, TARGET_TAP, DELAY_LINE_OUT_OF_RANGE,
    input  DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           CUR_TAP, BUSY, DONE, LANE_ERR
  );

  // Trainer side.
  modport slave (
    input  START, LANE_MASK, TARGET_TAP, DELAY_LINE_OUT_OF_RANGE,
    output DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           CUR_TAP, BUSY, DONE, LANE_ERR
  );
endinterface

// File: rtl/ddr_dly_gap_timer.sv
// Loadable idle-gap down-counter; expired_o marks the last cycle of the gap.
module ddr_dly_gap_timer #(
  parameter int unsigned GAP = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CW = $clog2(GAP + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload on a pulse, otherwise count down while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(GAP);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(1));
endmodule

// File: rtl/ddr4_ca_dly_trainer.sv
// Walks each unmasked CA lane: LOAD, then MOVE pulses until the tracked tap
// reaches the lane target, with sticky per-lane out-of-range reporting.
module ddr4_ca_dly_trainer
  import ddr4_ca_pkg::*;
#(
  parameter int unsigned NUM_LANES = 14,
  parameter int unsigned TAP_W     = 8,
  parameter int unsigned LOAD_VAL  = 1,
  parameter int unsigned MOVE_GAP  = 4
) (
  input  logic                    FAB_CLK,
  input  logic                    TX_SYNC_RST,
  ddr4_ca_dly_trainer_if.slave    bus
);
  localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  typedef logic [TAP_W-1:0] lane_tap_t;
  localparam lane_tap_t      LOAD_TAP  = lane_tap_t'(LOAD_VAL);
  localparam lane_tap_t      ONE_TAP   = lane_tap_t'(1);
  localparam lane_tap_t      TAP_TOP   = '1;
  localparam logic [LW-1:0]  LAST_LANE = LW'(NUM_LANES - 1);

  state_e               state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic [NUM_LANES-1:0] err_q, err_d;
  lane_tap_t            tgt_q [NUM_LANES];
  lane_tap_t            tgt_d [NUM_LANES];
  lane_tap_t            tap_q [NUM_LANES];
  lane_tap_t            tap_d [NUM_LANES];
  logic                 dir_q, dir_d;
  logic                 oor_q, oor_d;
  logic                 stepped_q, stepped_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 gap_load, gap_en, gap_expired;
  logic [NUM_LANES-1:0] load_vec, move_vec, dir_vec;
  lane_tap_t            cur_tap, cur_tgt;
  logic [NUM_LANES*TAP_W-1:0] cur_tap_flat;

  assign cur_tap = tap_q[lane_q];
  assign cur_tgt = tgt_q[lane_q];

  ddr_dly_gap_timer #(
    .GAP (MOVE_GAP)
  ) u_gap (
    .clk_i     (FAB_CLK),
    .rst_i     (TX_SYNC_RST),
    .load_i    (gap_load),
    .en_i      (gap_en),
    .expired_o (gap_expired)
  );

  // Next-state, tap tracking and per-lane pulse decode.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    mask_d    = mask_q;
    tgt_d     = tgt_q;
    tap_d     = tap_q;
    err_d     = err_q;
    dir_d     = dir_q;
    oor_d     = oor_q;
    stepped_d = stepped_q;
    busy_d    = busy_q;
    done_d    = done_q;
    gap_load  = 1'b0;
    gap_en    = 1'b0;
    load_vec  = '0;
    move_vec  = '0;
    dir_vec   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          mask_d = bus.LANE_MASK;
          for (int unsigned i = 0; i < NUM_LANES; i++) begin
            tgt_d[i] = bus.TARGET_TAP[i*TAP_W +: TAP_W];
          end
          err_d   = '0;
          done_d  = 1'b0;
          lane_d  = '0;
          busy_d  = 1'b1;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        state_d = mask_q[lane_q] ? S_LOAD : S_NEXT;
      end
      S_LOAD: begin
        load_vec[lane_q] = 1'b1;
        tap_d[lane_q]    = LOAD_TAP;
        stepped_d        = 1'b0;
        gap_load         = 1'b1;
        state_d          = S_WAIT;
      end
      S_WAIT: begin
        gap_en = 1'b1;
        // Direction and range flag only matter in the gap following a MOVE.
        if (stepped_q) begin
          dir_vec[lane_q] = dir_q;
          if (bus.DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
            oor_d = 1'b1;
          end
        end
        if (gap_expired) begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (oor_q) begin
          err_d[lane_q] = 1'b1;
          tap_d[lane_q] = dir_q ? (cur_tap - ONE_TAP) : (cur_tap + ONE_TAP);
          state_d       = S_NEXT;
        end else if (cur_tap == cur_tgt) begin
          state_d = S_NEXT;
        end else begin
          dir_d           = (cur_tgt > cur_tap);
          dir_vec[lane_q] = dir_d;
          state_d         = S_STEP;
        end
      end
      S_STEP: begin
        move_vec[lane_q] = 1'b1;
        dir_vec[lane_q]  = dir_q;
        if (dir_q && (cur_tap != TAP_TOP)) begin
          tap_d[lane_q] = cur_tap + ONE_TAP;
        end else if (!dir_q && (cur_tap != '0)) begin
          tap_d[lane_q] = cur_tap - ONE_TAP;
        end
        stepped_d = 1'b1;
        gap_load  = 1'b1;
        state_d   = S_WAIT;
      end
      S_NEXT: begin
        oor_d = 1'b0;
        if (lane_q == LAST_LANE) begin
          state_d = S_FIN;
        end else begin
          lane_d  = lane_q + LW'(1);
          state_d = S_SEL;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      mask_q    <= '0;
      err_q     <= '0;
      dir_q     <= 1'b0;
      oor_q     <= 1'b0;
      stepped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        tgt_q[i] <= '0;
        tap_q[i] <= LOAD_TAP;
      end
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
      dir_q     <= dir_d;
      oor_q     <= oor_d;
      stepped_q <= stepped_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        tgt_q[i] <= tgt_d[i];
        tap_q[i] <= tap_d[i];
      end
    end
  end

  // Flatten tracked taps onto the lane-packed output bus.
  always_comb begin
    cur_tap_flat = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      cur_tap_flat[i*TAP_W +: TAP_W] = tap_q[i];
    end
  end

  assign bus.DELAY_LINE_LOAD      = load_vec;
  assign bus.DELAY_LINE_MOVE      = move_vec;
  assign bus.DELAY_LINE_DIRECTION = dir_vec;
  assign bus.CUR_TAP              = cur_tap_flat;
  assign bus.BUSY                 = busy_q;
  assign bus.DONE                 = done_q;
  assign bus.LANE_ERR             = err_q;
endmodule

// File: tb/tb_ddr4_ca_dly_trainer.sv
// Self-checking bench for ddr4_ca_dly_trainer (4 lanes, 8-bit taps, gap 2).
module tb_ddr4_ca_dly_trainer;
  localparam int NL   = 4;
  localparam int TW   = 8;
  localparam int LV   = 1;
  localparam int G    = 2;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr4_ca_dly_trainer_if #(.NUM_LANES(NL), .TAP_W(TW)) bus ();

  ddr4_ca_dly_trainer #(
    .NUM_LANES (NL),
    .TAP_W     (TW),
    .LOAD_VAL  (LV),
    .MOVE_GAP  (G)
  ) dut (
    .FAB_CLK     (clk),
    .TX_SYNC_RST (rst),
    .bus         (bus)
  );

  int nchk  = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Expected per-cycle behaviour of one pass, cycle 0 = first cycle after the
  // START-sampling edge.
  logic [NL-1:0] e_load [MAXC];
  logic [NL-1:0] e_move [MAXC];
  logic [NL-1:0] e_dir  [MAXC];
  logic [NL-1:0] e_oor  [MAXC];
  bit            e_dchk [MAXC];
  int            e_last;           // first cycle showing DONE
  logic [TW-1:0] sh_tap [NL];      // expected tracked taps
  logic [NL-1:0] m_err;

  // Timeline per lane: SEL, LOAD, G gap cycles, CMP, then per move
  // STEP + G gap + CMP (G+2 cycles), then NEXT. A masked lane is SEL, NEXT.
  task automatic model(input logic [NL-1:0] mask, input logic [31:0] tgt,
                       input int oor_lane, input int oor_move);
    int t, c0, n, nm, s, tv;
    bit up, hit;
    for (int k = 0; k < MAXC; k++) begin
      e_load[k] = '0; e_move[k] = '0; e_dir[k] = '0; e_oor[k] = '0; e_dchk[k] = 1'b0;
    end
    m_err = '0;
    t = 0;
    for (int l = 0; l < NL; l++) begin
      if (!mask[l]) begin
        t = t + 2;
      end else begin
        tv = int'(tgt[l*TW +: TW]);
        e_load[t+1][l] = 1'b1;
        // range flag noise in the post-LOAD gap must be ignored
        for (int w = 1; w <= G; w++) e_oor[t+1+w][l] = 1'($urandom_range(0, 1));
        c0  = t + 2 + G;
        up  = (tv > LV);
        n   = up ? tv - LV : LV - tv;
        hit = (oor_lane == l) && (oor_move >= 1) && (oor_move <= n);
        nm  = hit ? oor_move : n;
        for (int j = 1; j <= nm; j++) begin
          s = c0 + 1 + (j - 1) * (G + 2);
          e_move[s][l]   = 1'b1;
          e_dir[s][l]    = up;
          e_dir[s-1][l]  = up;
          e_dchk[s]      = 1'b1;
          e_dchk[s-1]    = 1'b1;
          if (hit && j == nm)
            for (int w = 1; w <= G; w++) e_oor[s+w][l] = 1'b1;
        end
        if (hit) begin
          m_err[l]  = 1'b1;
          sh_tap[l] = up ? TW'(LV + nm - 1) : TW'(LV - (nm - 1));
        end else begin
          sh_tap[l] = TW'(tv);
        end
        t = c0 + nm * (G + 2) + 2;
      end
    end
    e_last = t + 1;
  endtask

  function automatic logic [31:0] pack_taps();
    logic [31:0] v;
    for (int l = 0; l < NL; l++) v[l*TW +: TW] = sh_tap[l];
    return v;
  endfunction

  task automatic run_pass(input logic [NL-1:0] mask, input logic [31:0] tgt,
                          input int oor_lane, input int oor_move, input bit glitch);
    int gk;
    model(mask, tgt, oor_lane, oor_move);
    gk = glitch ? $urandom_range(1, e_last - 1) : -1;
    @(negedge clk);
    bus.START = 1'b1;
    bus.LANE_MASK = mask;
    bus.TARGET_TAP = tgt;
    bus.DELAY_LINE_OUT_OF_RANGE = '0;
    @(posedge clk);
    for (int k = 0; k <= e_last; k++) begin
      @(negedge clk);
      bus.START = (k == gk);
      if (k == gk) begin
        bus.LANE_MASK  = NL'($urandom);
        bus.TARGET_TAP = $urandom;
      end
      bus.DELAY_LINE_OUT_OF_RANGE = e_oor[k] | (NL'($urandom) & ~mask);
      chk("load", 32'(bus.DELAY_LINE_LOAD), 32'(e_load[k]));
      chk("move", 32'(bus.DELAY_LINE_MOVE), 32'(e_move[k]));
      chk("busy", 32'(bus.BUSY), 32'(k < e_last));
      chk("done", 32'(bus.DONE), 32'(k >= e_last));
      if (e_dchk[k]) chk("direction", 32'(bus.DELAY_LINE_DIRECTION), 32'(e_dir[k]));
    end
    bus.START = 1'b0;
    bus.DELAY_LINE_OUT_OF_RANGE = '0;
    chk("cur_tap", bus.CUR_TAP, pack_taps());
    chk("lane_err", 32'(bus.LANE_ERR), 32'(m_err));
  endtask

  typedef struct {
    logic [NL-1:0] mask;
    logic [31:0]   tgt;
    int            oor_lane;
    int            oor_move;
    logic [NL-1:0] exp_err;
    logic [31:0]   exp_tap;
  } vec_t;

  vec_t tbl [5];

  initial begin
    bit found;

    tbl[0] = '{mask: 4'b0001, tgt: 32'h00000005, oor_lane: -1, oor_move: 0,
               exp_err: 4'b0000, exp_tap: 32'h01010105};
    tbl[1] = '{mask: 4'b0011, tgt: 32'h00000100, oor_lane: -1, oor_move: 0,
               exp_err: 4'b0000, exp_tap: 32'h01010100};
    tbl[2] = '{mask: 4'b0000, tgt: 32'h09090909, oor_lane: -1, oor_move: 0,
               exp_err: 4'b0000, exp_tap: 32'h01010100};
    tbl[3] = '{mask: 4'b1100, tgt: 32'h070A0000, oor_lane: 2, oor_move: 3,
               exp_err: 4'b0100, exp_tap: 32'h07030100};
    tbl[4] = '{mask: 4'b0001, tgt: 32'h00000002, oor_lane: -1, oor_move: 0,
               exp_err: 4'b0000, exp_tap: 32'h07030102};

    // Reset state, with START held high during reset.
    rst = 1'b1;
    bus.START = 1'b1;
    bus.LANE_MASK = '1;
    bus.TARGET_TAP = 32'h05050505;
    bus.DELAY_LINE_OUT_OF_RANGE = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load", 32'(bus.DELAY_LINE_LOAD), 32'h0);
    chk("rst_move", 32'(bus.DELAY_LINE_MOVE), 32'h0);
    chk("rst_dir", 32'(bus.DELAY_LINE_DIRECTION), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_done", 32'(bus.DONE), 32'h0);
    chk("rst_err", 32'(bus.LANE_ERR), 32'h0);
    chk("rst_tap", bus.CUR_TAP, 32'h01010101);
    rst = 1'b0;
    bus.START = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(bus.BUSY), 32'h0);
    chk("idle_load", 32'(bus.DELAY_LINE_LOAD), 32'h0);
    for (int l = 0; l < NL; l++) sh_tap[l] = TW'(LV);

    // Directed table: timing against the model, end state against the table.
    for (int i = 0; i < 5; i++) begin
      run_pass(tbl[i].mask, tbl[i].tgt, tbl[i].oor_lane, tbl[i].oor_move, 1'b0);
      chk($sformatf("tbl%0d_tap", i), bus.CUR_TAP, tbl[i].exp_tap);
      chk($sformatf("tbl%0d_err", i), 32'(bus.LANE_ERR), 32'(tbl[i].exp_err));
    end

    // Reset in the middle of a STEP.
    @(negedge clk);
    bus.START = 1'b1;
    bus.LANE_MASK = 4'b0001;
    bus.TARGET_TAP = 32'h00000005;
    @(posedge clk);
    @(negedge clk);
    bus.START = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.DELAY_LINE_MOVE != '0) found = 1'b1;
      else @(negedge clk);
    end
    chk("move_seen", 32'(found), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_move", 32'(bus.DELAY_LINE_MOVE), 32'h0);
    chk("abort_load", 32'(bus.DELAY_LINE_LOAD), 32'h0);
    chk("abort_busy", 32'(bus.BUSY), 32'h0);
    chk("abort_tap", bus.CUR_TAP, 32'h01010101);
    for (int l = 0; l < NL; l++) sh_tap[l] = TW'(LV);
    run_pass(4'b0001, 32'h00000005, -1, 0, 1'b1);

    // Randomised passes with range faults and ignored START pulses.
    for (int r = 0; r < 10; r++) begin
      logic [31:0] tg;
      for (int l = 0; l < NL; l++) tg[l*TW +: TW] = TW'($urandom_range(0, 12));
      run_pass(NL'($urandom), tg, $urandom_range(0, 4), $urandom_range(1, 5), 1'b1);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
